// File: rtl/scoped_elastic_pipe.sv
// Elastic valid/ready pipeline of DEPTH stages. Each stage keeps its valid/data pair in
// its own generate scope. Also provides output parity, occupancy and a sticky upstream-violation flag.
module scoped_elastic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy,
    output logic             overflow_err
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] prev_data;

    task automatic stage_step(
        input  logic             adv_i,
        input  logic             flush_i,
        input  logic             v_cur,
        input  logic [WIDTH-1:0] d_cur,
        input  logic             v_up,
        input  logic [WIDTH-1:0] d_up,
        output logic             v_nxt,
        output logic [WIDTH-1:0] d_nxt
    );
        v_nxt = v_cur;
        d_nxt = d_cur;
        if (adv_i) begin
            v_nxt = v_up;
            // bubbles and flushed words never overwrite the held data
            if (v_up && !flush_i) d_nxt = d_up;
        end
        if (flush_i) v_nxt = 1'b0;
    endtask

    function automatic logic parity_of(input logic [WIDTH-1:0] w);
        logic p;
        p = 1'b0;
        for (int b = 0; b < WIDTH; b++) p = p ^ w[b];
        return p;
    endfunction

    // A stage may advance when it is empty or everything downstream can move.
    always_comb begin
        logic chain;
        chain = out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = !vld[i] || chain;
            adv[i] = chain;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v;
        logic [WIDTH-1:0] d;
        logic             v_up;
        logic             v_nxt;
        logic [WIDTH-1:0] d_up;
        logic [WIDTH-1:0] d_nxt;

        if (i == 0) begin : g_head
            assign v_up = in_valid;
            assign d_up = in_data;
        end else begin : g_link
            assign v_up = vld[i-1];
            assign d_up = dat[i-1];
        end

        always_comb stage_step(adv[i], flush, v, d, v_up, d_up, v_nxt, d_nxt);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                d <= '0;
            end else begin
                v <= v_nxt;
                d <= d_nxt;
            end
        end

        assign vld[i] = v;
        assign dat[i] = d;
    end

    assign in_ready   = adv[0];
    assign out_valid  = vld[DEPTH-1];
    assign out_data   = g_stage[DEPTH-1].d;
    assign out_parity = parity_of(dat[DEPTH-1]);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy    <= '0;
            overflow_err <= 1'b0;
            prev_data    <= '0;
        end else begin
            prev_data <= in_data;
            // upstream changed its word while stalled
            if (in_valid && !in_ready && (in_data != prev_data)) overflow_err <= 1'b1;
            if (flush)                     occupancy <= '0;
            else if (in_fire && !out_fire) occupancy <= occupancy + 1'b1;
            else if (out_fire && !in_fire) occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: tb/tb_scoped_elastic_pipe.sv
// Bench for scoped_elastic_pipe: directed scenarios followed by random traffic, all
// checked against a slot-level reference model and an in-order scoreboard.
module tb_scoped_elastic_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 2;
    localparam int LAST  = DEPTH - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CW-1:0]    occupancy;
    logic             overflow_err;

    always #5 clk = ~clk;

    scoped_elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_parity(out_parity),
        .out_ready(out_ready), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: which slots hold a word, what they hold, plus counters.
    bit               m_v [DEPTH];
    logic [WIDTH-1:0] m_d [DEPTH];
    int               m_occ;
    bit               m_ovf;
    logic [WIDTH-1:0] m_prev;
    logic [WIDTH-1:0] sb [$];

    logic [7:0] stream_exp [3] = '{8'h01, 8'h02, 8'h03};
    logic       stream_par [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] bp_exp     [3] = '{8'hA5, 8'h5A, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_v[i]) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_occ  = 0;
        m_ovf  = 1'b0;
        m_prev = '0;
        sb.delete();
    endtask

    // The pipe can take a word if any slot is free or the output is draining.
    function automatic bit m_ready();
        foreach (m_v[i]) if (!m_v[i]) return 1'b1;
        return out_ready;
    endfunction

    task automatic check_all();
        chk("in_ready", in_ready, m_ready());
        chk("out_valid", out_valid, m_v[LAST]);
        chk("occupancy", occupancy, m_occ);
        chk("overflow_err", overflow_err, m_ovf);
        if (m_v[LAST]) begin
            chk("out_data", out_data, m_d[LAST]);
            chk("out_parity", out_parity, ^m_d[LAST]);
        end
    endtask

    task automatic model_step();
        bit rdy;
        bit in_f;
        bit out_f;
        rdy   = m_ready();
        in_f  = in_valid && rdy;
        out_f = m_v[LAST] && out_ready;
        if (in_valid && !rdy && (in_data !== m_prev)) m_ovf = 1'b1;
        m_prev = in_data;
        if (flush) begin
            foreach (m_v[i]) m_v[i] = 1'b0;
            m_occ = 0;
            sb.delete();
            return;
        end
        if (out_f) begin
            if (sb.size() > 0) chk("order", out_data, sb.pop_front());
            m_v[LAST] = 1'b0;
        end
        // each word moves one slot toward the output if the slot ahead is free
        for (int p = DEPTH - 2; p >= 0; p--) begin
            if (m_v[p] && !m_v[p+1]) begin
                m_v[p+1] = 1'b1;
                m_d[p+1] = m_d[p];
                m_v[p]   = 1'b0;
            end
        end
        if (in_f) begin
            m_v[0] = 1'b1;
            m_d[0] = in_data;
            sb.push_back(in_data);
        end
        m_occ += int'(in_f) - int'(out_f);
    endtask

    task automatic cycle();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst.out_data", out_data, 0);
        chk("rst.out_parity", out_parity, 0);
        check_all();

        // reset in the middle of a stream
        out_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.occupancy", occupancy, 0);
        chk("arst.in_ready", in_ready, 1);
        chk("arst.out_data", out_data, 0);
        model_reset();
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // streaming, unstalled
        out_ready = 1'b1;
        push(8'h01);
        push(8'h02);
        chk("stream.latency", out_valid, 0);
        push(8'h03);
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stream.valid", out_valid, 1);
            chk("stream.data", out_data, stream_exp[j]);
            chk("stream.parity", out_parity, stream_par[j]);
            cycle();
        end
        chk("stream.empty", out_valid, 0);

        // back-pressure fills the pipe, then drains
        out_ready = 1'b0;
        push(8'hA5);
        push(8'h5A);
        push(8'hFF);
        in_valid = 1'b0;
        #1;
        chk("bp.occupancy", occupancy, 3);
        chk("bp.in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp.drain_ready", in_ready, 1);
        for (int j = 0; j < 3; j++) begin
            chk("bp.valid", out_valid, 1);
            chk("bp.data", out_data, bp_exp[j]);
            cycle();
        end
        chk("bp.occ_end", occupancy, 0);
        chk("bp.valid_end", out_valid, 0);

        // simultaneous in and out fire at occupancy 2
        out_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        in_valid = 1'b0;
        cycle();
        chk("sim.occ_before", occupancy, 2);
        chk("sim.valid_before", out_valid, 1);
        in_valid  = 1'b1;
        in_data   = 8'hB3;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("sim.occupancy", occupancy, 2);
        chk("sim.data", out_data, 8'hB2);
        repeat (4) cycle();
        chk("sim.occ_end", occupancy, 0);

        // flush discards held words and the word offered in the flush cycle
        out_ready = 1'b0;
        push(8'hC1);
        push(8'hC2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush.out_valid", out_valid, 0);
        chk("flush.occupancy", occupancy, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("flush.no77", (out_valid && out_data == 8'h77), 0);
            cycle();
        end

        // upstream changes its word while stalled
        out_ready = 1'b0;
        push(8'hD1);
        push(8'hD2);
        push(8'h10);
        cycle();
        chk("proto.hold_ok", overflow_err, 0);
        in_data = 8'h20;
        cycle();
        chk("proto.ovf", overflow_err, 1);
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        chk("proto.ovf_flush", overflow_err, 1);
        chk("proto.occ_flush", occupancy, 0);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("proto.ovf_rst", overflow_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
